vga_timing_stream: RTL and testbench
====================================

// Module: vga_timing_stream
// PURPOSE
// - Parametrised successor to the fixed-timing VGA generator; sits in the pixel_clk domain
//   between the frame-buffer pixel FIFO and video_if.
// - Generates HS/VS/BLANK from fully parametrised timing with selectable sync polarity.
// - Emits RGB either from a valid/ready pixel stream or from internal test patterns (grid, colour bars).
// - Flags stream underflow (sticky) and pulses start-of-frame for upstream DMA restart.
// PARAMETERS
// - HDISP   800  active pixels per line
// - VDISP   480  active lines per frame
// - HFP     40   horizontal front porch (pixels)
// - HPULSE  48   horizontal sync width (pixels)
// - HBP     40   horizontal back porch (pixels)
// - VFP     13   vertical front porch (lines)
// - VPULSE  3    vertical sync width (lines)
// - VBP     29   vertical back porch (lines)
// - HS_POL  0    active level of HS
// - VS_POL  0    active level of VS
// PORTS
// - pixel_clk      in   1   pixel clock; only clock of the block
// - pixel_rst      in   1   asynchronous reset, active high
// - enable         in   1   1 = run timing; 0 = hold idle, counters at 0
// - mode           in   2   0 = stream, 1 = grid, 2 = colour bars, 3 = black
// - pix_data       in   24  stream pixel {R,G,B}
// - pix_valid      in   1   pix_data valid
// - pix_ready      out  1   pixel consumed this cycle (combinational from counters/mode)
// - underflow_clr  in   1   clears underflow
// - HS             out  1   horizontal sync (registered)
// - VS             out  1   vertical sync (registered)
// - BLANK          out  1   1 = active display region (registered)
// - RGB            out  24  pixel out (registered, aligned with BLANK)
// - sof            out  1   one-cycle start-of-frame pulse (registered)
// - underflow      out  1   sticky: ready while !valid
// BEHAVIOUR
// - HTOTAL = HFP+HPULSE+HBP+HDISP and VTOTAL = VFP+VPULSE+VBP+VDISP.
// - HSTART = HFP+HPULSE+HBP and VSTART = VFP+VPULSE+VBP.
// - Counter widths are $clog2(HTOTAL) and $clog2(VTOTAL).
// - Reset state: h = v = 0; HS = ~HS_POL, VS = ~VS_POL; BLANK = 0, RGB = 0, sof = 0, underflow = 0.
// - The active mode register also resets to 0 (stream).
// - Counters while enable = 1:
//   - h increments each cycle and wraps HTOTAL-1 -> 0.
//   - v increments when h = HTOTAL-1 and wraps VTOTAL-1 -> 0 on the same edge.
// - enable = 0 (including mid-frame):
//   - Counters are forced to 0 on the next edge.
//   - Outputs go to their reset values one cycle later; pix_ready = 0.
//   - Re-enable restarts at (0,0), i.e. a full new frame.
// - Regions at counter value (h,v), all registered, so outputs lag counters by exactly 1 cycle:
//   - HS = HS_POL iff HFP <= h < HFP+HPULSE, else ~HS_POL.
//   - VS = VS_POL iff VFP <= v < VFP+VPULSE, else ~VS_POL.
//   - act = (h >= HSTART) && (v >= VSTART) && enable; BLANK <= act.
// - sof <= enable && h == 0 && v == 0.
// - mode is sampled into the active-mode register only when enable && h == 0 && v == 0.
//   Mid-frame changes take effect at the next frame.
// - Stream mode (active mode 0):
//   - pix_ready = act.
//   - If pix_valid, RGB <= pix_data; otherwise RGB <= 0 and underflow <= 1.
//   - Exactly HDISP*VDISP pixels are consumed per frame. No back-pressure outside act.
// - Pattern modes: pix_ready = 0; pix_valid and pix_data are ignored; underflow is never set.
//   - x = h - HSTART and y = v - VSTART.
//   - Grid: RGB = FFFFFF when x[3:0] == 0 or y[3:0] == 0, else 0.
//   - Bars: 8 vertical bars, each BARW = HDISP/8 pixels wide (integer divide).
//     - Colour index = bar counter, clamped at 7 for the remainder pixels.
//     - Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
//     - The bar counter is driven by a sub-counter reset at x = 0. No divider in RTL.
//   - Mode 3: RGB = 0.
// - Outside act, RGB <= 0 in every mode.
// - underflow_clr and an underflow event in the same cycle: the set wins.
// - Asynchronous reset mid-frame returns every output to its reset value immediately. Next frame starts at (0,0).
// TESTING
// - Small timing (HDISP=8, VDISP=4, porches/pulses 2,2,2 / 1,1,1, i.e. HTOTAL=14, VTOTAL=7):
//   - HS active during cycles 3-4 of each line; VS active during line 1.
//   - BLANK high 8 cycles per line on lines 3-6; sof period = 98 cycles.
// - Reset: hold pixel_rst 3 cycles with HS_POL=0 -> HS=1, VS=1, BLANK=0, RGB=0, sof=0, underflow=0.
// - Stream: always-valid counting data -> 32 pixel_ready pulses per frame.
//   - RGB matches pix_data 1 cycle later; underflow stays 0.
// - Underflow: drop pix_valid for pixel 5 -> RGB=0 for that pixel and underflow=1 until underflow_clr.
//   - A clear in the same cycle as a new underflow event -> underflow stays 1.
// - Mode change mid-frame: switch 0 -> 1 at line 4.
//   - The current frame stays in stream mode; the next frame shows the grid (x=0 column white).
//   - pix_ready = 0 throughout the grid frame.
// - Enable dropped at (h=9,v=5) for 10 cycles:
//   - Outputs idle one cycle after the drop.
//   - After re-enable, sof fires on the first cycle, and the full 98-cycle frame repeats.

Source files
------------

// File: rtl/vga_timing_stream.sv
// vga_timing_stream: parametrised VGA sync/blank generator with stream or test-pattern RGB
module vga_timing_stream #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        underflow_clr,
  output logic        HS,
  output logic        VS,
  output logic        BLANK,
  output logic [23:0] RGB,
  output logic        sof,
  output logic        underflow
);
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int HTOTAL = HSTART + HDISP;
  localparam int VTOTAL = VSTART + VDISP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam int BARW = HDISP / 8;
  localparam int BW = BARW > 1 ? $clog2(BARW) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] H_ST = HW'(HSTART);
  localparam logic [VW-1:0] V_ST = VW'(VSTART);
  localparam logic [HW-1:0] HS_A = HW'(HFP);
  localparam logic [HW-1:0] HS_B = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] VS_A = VW'(VFP);
  localparam logic [VW-1:0] VS_B = VW'(VFP + VPULSE);
  localparam logic [BW-1:0] BX_LAST = BW'(BARW - 1);
  localparam logic [23:0] BAR_C [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    mode_q, mode_d;
  logic [BW-1:0] bx_q, bx_d;
  logic [2:0]    bar_q, bar_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, sof_q, uf_q, uf_d;
  logic [23:0]   rgb_q, rgb_d, pat;
  logic [3:0]    gx, gy;
  logic          act, fs, h_end;
  // Counter advance, region decode and next pixel selection; bar counters track the current h
  always_comb begin
    h_end = h_q == H_LAST;
    fs = enable && h_q == '0 && v_q == '0;
    act = enable && h_q >= H_ST && v_q >= V_ST;
    pix_ready = act && mode_q == 2'd0;
    h_d = (!enable || h_end) ? '0 : h_q + 1'b1;
    v_d = !enable ? '0 : h_end ? (v_q == V_LAST ? '0 : v_q + 1'b1) : v_q;
    mode_d = fs ? mode : mode_q;
    bx_d = (h_d == H_ST || bx_q == BX_LAST) ? '0 : bx_q + 1'b1;
    bar_d = h_d == H_ST ? 3'd0 : (bx_q == BX_LAST && bar_q != 3'd7) ? bar_q + 3'd1 : bar_q;
    gx = 4'(h_q - H_ST);
    gy = 4'(v_q - V_ST);
    pat = mode_q == 2'd1 ? ((gx == 4'd0 || gy == 4'd0) ? 24'hFFFFFF : 24'h0) :
          mode_q == 2'd2 ? BAR_C[bar_q] : 24'h0;
    rgb_d = !act ? 24'h0 : mode_q == 2'd0 ? (pix_valid ? pix_data : 24'h0) : pat;
    hs_d = (enable && h_q >= HS_A && h_q < HS_B) ? HS_POL : ~HS_POL;
    vs_d = (enable && v_q >= VS_A && v_q < VS_B) ? VS_POL : ~VS_POL;
    uf_d = enable && ((pix_ready && !pix_valid) || (uf_q && !underflow_clr));
  end
  // State and registered outputs; disable idles everything one edge after enable falls
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      h_q <= '0;
      v_q <= '0;
      mode_q <= 2'd0;
      bx_q <= '0;
      bar_q <= 3'd0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      blank_q <= 1'b0;
      rgb_q <= 24'h0;
      sof_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      mode_q <= mode_d;
      bx_q <= bx_d;
      bar_q <= bar_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      blank_q <= act;
      rgb_q <= rgb_d;
      sof_q <= fs;
      uf_q <= uf_d;
    end
  end
  assign HS = hs_q;
  assign VS = vs_q;
  assign BLANK = blank_q;
  assign RGB = rgb_q;
  assign sof = sof_q;
  assign underflow = uf_q;
endmodule

// File: tb/tb_vga_timing_stream.sv
// tb_vga_timing_stream: randomized directed bench against a frame-position reference model
module tb_vga_timing_stream;
  localparam int HD = 8, VD = 4, HF = 2, HP = 2, HB = 2, VF = 1, VP = 1, VB = 1;
  localparam int HT = HF + HP + HB + HD, VT = VF + VP + VB + VD, FR = HT * VT;
  localparam int HS0 = HF + HP + HB, VS0 = VF + VP + VB;
  logic clk = 0, rst = 1, en = 0, vld = 0, clr = 0;
  logic [1:0] md = 0;
  logic [23:0] dat = 0;
  logic rdy, hs, vs, blank, sof, uf;
  logic [23:0] rgb;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int nchk = 0, nfail = 0, p = 0, fm = 0, rdy_cnt = 0;
  logic muf = 0;
  vga_timing_stream #(.HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
                      .VFP(VF), .VPULSE(VP), .VBP(VB), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .mode(md), .pix_data(dat),
    .pix_valid(vld), .pix_ready(rdy), .underflow_clr(clr), .HS(hs), .VS(vs),
    .BLANK(blank), .RGB(rgb), .sof(sof), .underflow(uf));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_hs"}, 24'(hs), 24'd1);
    chk({tag, "_vs"}, 24'(vs), 24'd1);
    chk({tag, "_blank"}, 24'(blank), 24'd0);
    chk({tag, "_rgb"}, rgb, 24'd0);
    chk({tag, "_sof"}, 24'(sof), 24'd0);
    chk({tag, "_uf"}, 24'(uf), 24'd0);
  endtask
  task automatic step();
    int h, v, x, y, bi;
    logic act, e_rdy;
    logic [23:0] e_rgb;
    h = p % HT;
    v = p / HT;
    x = h - HS0;
    y = v - VS0;
    act = en && h >= HS0 && v >= VS0;
    e_rdy = act && fm == 0;
    bi = act ? x / (HD / 8) : 0;
    if (bi > 7) bi = 7;
    e_rgb = !act ? 24'h0 : fm == 0 ? (vld ? dat : 24'h0) :
            fm == 1 ? ((x % 16 == 0 || y % 16 == 0) ? 24'hFFFFFF : 24'h0) :
            fm == 2 ? bar_tab[bi] : 24'h0;
    #1;
    chk("pix_ready", 24'(rdy), 24'(e_rdy));
    if (rdy) rdy_cnt++;
    @(posedge clk);
    #1;
    muf = en && ((e_rdy && !vld) || (muf && !clr));
    chk("HS", 24'(hs), 24'(!(en && h >= HF && h < HF + HP)));
    chk("VS", 24'(vs), 24'(!(en && v >= VF && v < VF + VP)));
    chk("BLANK", 24'(blank), 24'(act));
    chk("RGB", rgb, e_rgb);
    chk("sof", 24'(sof), 24'(en && p == 0));
    chk("underflow", 24'(uf), 24'(muf));
    if (en) begin
      if (p == 0) fm = md;
      p = (p + 1) % FR;
    end else p = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 0;
    repeat (2) step();
    en = 1;
    vld = 1;
    rdy_cnt = 0;
    for (int i = 0; i < FR; i++) begin dat = $urandom; step(); end
    chk("ready_per_frame", 24'(rdy_cnt), 24'd32);
    rdy_cnt = 0;
    for (int i = 0; i < FR; i++) begin dat = $urandom; vld = rdy_cnt != 5; step(); end
    chk("uf_sticky", 24'(uf), 24'd1);
    rdy_cnt = 0;
    for (int i = 0; i < FR; i++) begin
      dat = $urandom;
      clr = i == 0 || rdy_cnt == 3;
      vld = rdy_cnt != 3;
      step();
      if (i == 0) chk("uf_cleared", 24'(uf), 24'd0);
    end
    clr = 0;
    chk("uf_set_wins", 24'(uf), 24'd1);
    for (int i = 0; i < FR; i++) begin
      dat = $urandom;
      vld = $urandom_range(0, 7) != 0;
      clr = $urandom_range(0, 15) == 0;
      step();
    end
    clr = 0;
    vld = 1;
    for (int i = 0; i < FR; i++) begin dat = $urandom; md = i >= 4 * HT ? 2'd1 : 2'd0; step(); end
    rdy_cnt = 0;
    for (int i = 0; i < FR; i++) begin dat = $urandom; step(); end
    chk("grid_no_ready", 24'(rdy_cnt), 24'd0);
    md = 2;
    for (int i = 0; i < FR; i++) begin dat = $urandom; vld = $urandom_range(0, 1) != 0; step(); end
    md = 3;
    for (int i = 0; i < FR; i++) step();
    md = 0;
    vld = 1;
    for (int i = 0; i < 5 * HT + 9; i++) begin dat = $urandom; step(); end
    en = 0;
    step();
    chk_idle("disable");
    repeat (9) step();
    en = 1;
    step();
    chk("sof_restart", 24'(sof), 24'd1);
    for (int i = 1; i < FR; i++) begin dat = $urandom; step(); end
    for (int i = 0; i < 40; i++) begin dat = $urandom; step(); end
    #2 rst = 1;
    #1;
    chk_idle("async_rst");
    @(posedge clk);
    #1;
    rst = 0;
    p = 0;
    fm = 0;
    muf = 0;
    for (int i = 0; i < FR; i++) begin dat = $urandom; step(); end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
